// File: rtl/dm_port_arbiter_if.sv
// rtl/dm_port_arbiter_if.sv - Data-memory port bundle shared by CPU, loader and MMU.
interface dm_port_arbiter_if;
   logic        m0_req;
   logic        m0_we;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic [3:0]  m0_be;
   logic        m0_signed;
   logic        m0_gnt;
   logic        m0_rvalid;
   logic [31:0] m0_rdata;

   logic        m1_req;
   logic        m1_we;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic [3:0]  m1_be;
   logic        m1_signed;
   logic        m1_lock;
   logic        m1_gnt;
   logic        m1_rvalid;
   logic [31:0] m1_rdata;

   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_di;
   logic [3:0]  dm_be;
   logic        is_signed;
   logic [31:0] dm_do;
   logic        cpu_stall;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata, m0_be, m0_signed,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_signed, m1_lock,
      input  dm_do,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output dm_we, dm_addr, dm_di, dm_be, is_signed, cpu_stall
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata, m0_be, m0_signed,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_signed, m1_lock,
      output dm_do,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  dm_we, dm_addr, dm_di, dm_be, is_signed, cpu_stall
   );
endinterface

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - CPU/loader arbiter for the single MMU data-memory port.
module dm_port_arbiter #(
   parameter int MAX_WAIT = 8,
   parameter int WAIT_W   = 8
) (
   input logic               clk,
   input logic               resetb,
   dm_port_arbiter_if.slave  bus
);
   localparam logic [0:0] ST_UNLOCKED = 1'b0;
   localparam logic [0:0] ST_LOCKED   = 1'b1;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_M0   = 2'd1;
   localparam logic [1:0] OWN_M1   = 2'd2;

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

   logic [0:0]        lock_st;
   logic [WAIT_W-1:0] wait_cnt;
   logic [1:0]        owner_p;
   logic              locked;
   logic              starved;
   logic              grant_m0;
   logic              grant_m1;

   assign locked  = (lock_st == ST_LOCKED);
   assign starved = (wait_cnt == WAIT_LIMIT);

   // While locked the CPU is shut out even if the loader momentarily drops req.
   assign grant_m1 = bus.m1_req && (locked || starved || !bus.m0_req);
   assign grant_m0 = bus.m0_req && !locked && !grant_m1;

   always_comb begin
      bus.dm_we     = 1'b0;
      bus.dm_addr   = 32'h0;
      bus.dm_di     = 32'h0;
      bus.dm_be     = 4'b0000;
      bus.is_signed = 1'b0;
      if (grant_m1) begin
         bus.dm_we     = bus.m1_we;
         bus.dm_addr   = bus.m1_addr;
         bus.dm_di     = bus.m1_wdata;
         bus.dm_be     = bus.m1_be;
         bus.is_signed = bus.m1_signed;
      end else if (grant_m0) begin
         bus.dm_we     = bus.m0_we;
         bus.dm_addr   = bus.m0_addr;
         bus.dm_di     = bus.m0_wdata;
         bus.dm_be     = bus.m0_be;
         bus.is_signed = bus.m0_signed;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         lock_st  <= ST_UNLOCKED;
         wait_cnt <= '0;
         owner_p  <= OWN_NONE;
      end else begin
         owner_p <= grant_m1 ? OWN_M1 : (grant_m0 ? OWN_M0 : OWN_NONE);

         if (!bus.m1_req || grant_m1)
            wait_cnt <= '0;
         else if (!starved)
            wait_cnt <= wait_cnt + 1'b1;

         if (lock_st == ST_UNLOCKED) begin
            if (grant_m1 && bus.m1_lock)
               lock_st <= ST_LOCKED;
         end else begin
            if (!bus.m1_lock || !bus.m1_req)
               lock_st <= ST_UNLOCKED;
         end
      end
   end

   assign bus.m0_gnt    = grant_m0;
   assign bus.m1_gnt    = grant_m1;
   assign bus.cpu_stall = bus.m0_req && !grant_m0;

   assign bus.m0_rvalid = (owner_p == OWN_M0);
   assign bus.m1_rvalid = (owner_p == OWN_M1);
   assign bus.m0_rdata  = (owner_p == OWN_M0) ? bus.dm_do : 32'h0;
   assign bus.m1_rdata  = (owner_p == OWN_M1) ? bus.dm_do : 32'h0;
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - Directed vector bench for dm_port_arbiter.
module tb_dm_port_arbiter;
   logic clk;
   logic resetb;
   int   checks;
   int   failures;

   dm_port_arbiter_if bus ();

   dm_port_arbiter #(.MAX_WAIT(8), .WAIT_W(8)) dut (
      .clk    (clk),
      .resetb (resetb),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        m0_req;
      logic        m0_we;
      logic [31:0] m0_addr;
      logic [31:0] m0_wdata;
      logic [3:0]  m0_be;
      logic        m0_sg;
      logic        m1_req;
      logic        m1_we;
      logic [31:0] m1_addr;
      logic [31:0] m1_wdata;
      logic [3:0]  m1_be;
      logic        m1_sg;
      logic        m1_lock;
      logic [31:0] dm_do;
      logic        e_m0_gnt;
      logic        e_m1_gnt;
      logic        e_dm_we;
      logic [31:0] e_dm_addr;
      logic [31:0] e_dm_di;
      logic [3:0]  e_dm_be;
      logic        e_sg;
      logic        e_m0_rv;
      logic        e_m1_rv;
      logic [31:0] e_m0_rd;
      logic [31:0] e_m1_rd;
      logic        e_stall;
   } vec_t;

   vec_t vecs [14];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic set_m0(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input logic sg);
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr;
      bus.m0_wdata = wdata; bus.m0_be = be; bus.m0_signed = sg;
   endtask

   task automatic set_m1(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input logic sg,
                         input logic lock);
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr;
      bus.m1_wdata = wdata; bus.m1_be = be; bus.m1_signed = sg; bus.m1_lock = lock;
   endtask

   task automatic idle();
      set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      bus.dm_do = 32'h0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetb = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      resetb = 1'b1;
   endtask

   task automatic apply_vec(input int i);
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      set_m0(v.m0_req, v.m0_we, v.m0_addr, v.m0_wdata, v.m0_be, v.m0_sg);
      set_m1(v.m1_req, v.m1_we, v.m1_addr, v.m1_wdata, v.m1_be, v.m1_sg, v.m1_lock);
      bus.dm_do = v.dm_do;
      #1;
      chk1 ($sformatf("v%0d_m0_gnt", i), bus.m0_gnt, v.e_m0_gnt);
      chk1 ($sformatf("v%0d_m1_gnt", i), bus.m1_gnt, v.e_m1_gnt);
      chk1 ($sformatf("v%0d_dm_we", i), bus.dm_we, v.e_dm_we);
      chk32($sformatf("v%0d_dm_addr", i), bus.dm_addr, v.e_dm_addr);
      chk32($sformatf("v%0d_dm_di", i), bus.dm_di, v.e_dm_di);
      chk32($sformatf("v%0d_dm_be", i), {28'h0, bus.dm_be}, {28'h0, v.e_dm_be});
      chk1 ($sformatf("v%0d_is_signed", i), bus.is_signed, v.e_sg);
      chk1 ($sformatf("v%0d_m0_rvalid", i), bus.m0_rvalid, v.e_m0_rv);
      chk1 ($sformatf("v%0d_m1_rvalid", i), bus.m1_rvalid, v.e_m1_rv);
      chk32($sformatf("v%0d_m0_rdata", i), bus.m0_rdata, v.e_m0_rd);
      chk32($sformatf("v%0d_m1_rdata", i), bus.m1_rdata, v.e_m1_rd);
      chk1 ($sformatf("v%0d_cpu_stall", i), bus.cpu_stall, v.e_stall);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      resetb   = 1'b0;
      idle();

      //        m0: req we addr wdata be sg | m1: req we addr wdata be sg lock | dm_do | gnt0 gnt1 we addr di be sg | rv0 rv1 rd0 rd1 | stall
      vecs[0]  = '{1'b1,1'b0,32'h10,32'h0,4'hF,1'b1, 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0, 32'h0,
                   1'b1,1'b0,1'b0,32'h10,32'h0,4'hF,1'b1, 1'b0,1'b0,32'h0,32'h0, 1'b0};
      vecs[1]  = '{1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0, 32'hDEAD0001,
                   1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b1,1'b0,32'hDEAD0001,32'h0, 1'b0};
      vecs[2]  = '{1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0, 32'h5,
                   1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b0,1'b0,32'h0,32'h0, 1'b0};
      vecs[3]  = '{1'b1,1'b0,32'h20,32'h0,4'hF,1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0, 32'h0,
                   1'b1,1'b0,1'b0,32'h20,32'h0,4'hF,1'b0, 1'b0,1'b0,32'h0,32'h0, 1'b0};
      vecs[4]  = '{1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b1,1'b0,32'h40,32'h0,4'hF,1'b1,1'b0, 32'h11,
                   1'b0,1'b1,1'b0,32'h40,32'h0,4'hF,1'b1, 1'b1,1'b0,32'h11,32'h0, 1'b0};
      vecs[5]  = '{1'b1,1'b0,32'h24,32'h0,4'hF,1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0, 32'h22,
                   1'b1,1'b0,1'b0,32'h24,32'h0,4'hF,1'b0, 1'b0,1'b1,32'h0,32'h22, 1'b0};
      vecs[6]  = '{1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0, 32'h33,
                   1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b1,1'b0,32'h33,32'h0, 1'b0};
      vecs[7]  = '{1'b1,1'b1,32'h30,32'h1234,4'h3,1'b0, 1'b1,1'b1,32'h50,32'hBEEF,4'hC,1'b0,1'b0, 32'h0,
                   1'b1,1'b0,1'b1,32'h30,32'h1234,4'h3,1'b0, 1'b0,1'b0,32'h0,32'h0, 1'b0};
      vecs[8]  = '{1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b1,1'b1,32'h50,32'hBEEF,4'hC,1'b0,1'b0, 32'h0,
                   1'b0,1'b1,1'b1,32'h50,32'hBEEF,4'hC,1'b0, 1'b1,1'b0,32'h0,32'h0, 1'b0};
      vecs[9]  = '{1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0, 32'h77,
                   1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b0,1'b1,32'h0,32'h77, 1'b0};
      vecs[10] = '{1'b1,1'b0,32'h60,32'h0,4'hF,1'b0, 1'b1,1'b1,32'h70,32'h55,4'hF,1'b0,1'b1, 32'h0,
                   1'b1,1'b0,1'b0,32'h60,32'h0,4'hF,1'b0, 1'b0,1'b0,32'h0,32'h0, 1'b0};
      vecs[11] = '{1'b1,1'b0,32'h64,32'h0,4'hF,1'b0, 1'b1,1'b1,32'h70,32'h55,4'hF,1'b0,1'b1, 32'h61,
                   1'b1,1'b0,1'b0,32'h64,32'h0,4'hF,1'b0, 1'b1,1'b0,32'h61,32'h0, 1'b0};
      vecs[12] = '{1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b1,1'b1,32'h70,32'h55,4'hF,1'b0,1'b0, 32'h62,
                   1'b0,1'b1,1'b1,32'h70,32'h55,4'hF,1'b0, 1'b1,1'b0,32'h62,32'h0, 1'b0};
      vecs[13] = '{1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0, 32'h9,
                   1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b0,1'b1,32'h0,32'h9, 1'b0};

      do_reset();
      @(negedge clk);
      bus.dm_do = 32'hFFFF_FFFF;
      #1;
      chk1 ("rst_m0_rvalid", bus.m0_rvalid, 1'b0);
      chk1 ("rst_m1_rvalid", bus.m1_rvalid, 1'b0);
      chk32("rst_m0_rdata", bus.m0_rdata, 32'h0);
      chk1 ("rst_dm_we", bus.dm_we, 1'b0);
      chk32("rst_dm_be", {28'h0, bus.dm_be}, 32'h0);

      for (int i = 0; i < 14; i++) apply_vec(i);

      // Starvation: m1 forced through at cycles 8 and 17 despite a constant CPU request.
      do_reset();
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         set_m0(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0);
         set_m1(1'b1, 1'b1, 32'h8000_0004, 32'hA5, 4'h1, 1'b0, 1'b0);
         bus.dm_do = 32'h0;
         #1;
         chk1($sformatf("starve_c%0d_m1_gnt", c), bus.m1_gnt, (c == 8 || c == 17));
         chk1($sformatf("starve_c%0d_stall", c), bus.cpu_stall, (c == 8 || c == 17));
         if (c == 8) begin
            chk1 ("starve_dm_we", bus.dm_we, 1'b1);
            chk32("starve_dm_addr", bus.dm_addr, 32'h8000_0004);
            chk32("starve_dm_di", bus.dm_di, 32'hA5);
            chk32("starve_dm_be", {28'h0, bus.dm_be}, 32'h1);
         end
      end

      // Locked burst: four loader writes, CPU requests from the second one.
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         set_m0(c >= 1, 1'b0, 32'h300, 32'h0, 4'hF, 1'b0);
         set_m1(c < 4, 1'b1, 32'h200 + 32'(4 * c), 32'h1000 + 32'(c), 4'hF, 1'b0, c < 3);
         bus.dm_do = 32'h0;
         #1;
         chk1($sformatf("burst_c%0d_m1_gnt", c), bus.m1_gnt, c < 4);
         chk1($sformatf("burst_c%0d_m0_gnt", c), bus.m0_gnt, c == 4);
         chk1($sformatf("burst_c%0d_stall", c), bus.cpu_stall, (c >= 1 && c < 4));
         chk1($sformatf("burst_c%0d_m1_rvalid", c), bus.m1_rvalid, c >= 1);
      end

      // Reset asserted in the cycle of a locked loader grant.
      do_reset();
      @(negedge clk);
      set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      set_m1(1'b1, 1'b1, 32'h400, 32'h1, 4'hF, 1'b0, 1'b1);
      #1;
      chk1("rlk_first_m1_gnt", bus.m1_gnt, 1'b1);
      @(negedge clk);
      set_m0(1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 1'b0);
      set_m1(1'b1, 1'b1, 32'h404, 32'h2, 4'hF, 1'b0, 1'b1);
      resetb = 1'b0;
      #1;
      chk1("rlk_locked_m1_gnt", bus.m1_gnt, 1'b1);
      chk1("rlk_locked_stall", bus.cpu_stall, 1'b1);
      @(negedge clk);
      resetb = 1'b1;
      bus.dm_do = 32'hABCD;
      #1;
      chk1 ("rlk_post_m1_rvalid", bus.m1_rvalid, 1'b0);
      chk32("rlk_post_m1_rdata", bus.m1_rdata, 32'h0);
      chk1 ("rlk_post_m0_gnt", bus.m0_gnt, 1'b1);
      chk1 ("rlk_post_m1_gnt", bus.m1_gnt, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory port of the MMU between two requesters: the CPU load/store stage (master 0) and the UART boot loader/debug writer (master 1).
- Grants at most one access per cycle and drives the MMU DM inputs.
- Tracks which master owns the one-cycle-latency read return and routes `dm_do` back to it.
- Fixed priority to the CPU, with a starvation limit and a loader bus-lock for bursts.

Parameters:
- MAX_WAIT, 8, consecutive cycles master 1 may be denied before it is forced to win one cycle (1..255).
- WAIT_W, 8, width of the starvation counter.

Ports:
- clk  input  1  clock
- resetb  input  1  synchronous active-low reset
- m0_req  input  1  CPU access request
- m0_we  input  1  CPU write enable
- m0_addr  input  32  CPU byte address
- m0_wdata  input  32  CPU write data, right-aligned
- m0_be  input  4  CPU byte enable (one-hot byte, 0011/1100 half, 1111 word)
- m0_signed  input  1  CPU load sign-extend
- m0_gnt  output  1  CPU request accepted this cycle
- m0_rvalid  output  1  CPU read/write completion, one cycle after grant
- m0_rdata  output  32  CPU read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_signed  input  1/1/32/32/4/1  loader request fields, same meaning as m0
- m1_lock  input  1  loader requests bus ownership across consecutive accesses
- m1_gnt  output  1  loader request accepted
- m1_rvalid  output  1  loader completion
- m1_rdata  output  32  loader read data
- dm_we  output  1  to MMU write enable
- dm_addr  output  32  to MMU address
- dm_di  output  32  to MMU write data
- dm_be  output  4  to MMU byte enable
- is_signed  output  1  to MMU sign select
- dm_do  input  32  from MMU read data (valid one cycle after access)
- cpu_stall  output  1  m0_req high and m0_gnt low

Behaviour:
- Reset (resetb low at posedge clk): wait_cnt=0, locked=0, owner_p=NONE, m0_rvalid=m1_rvalid=0. Reset takes priority over all other events. An access granted in the reset cycle produces no rvalid.
- Grant is combinational from current inputs and registered state:
  - locked=1 and m1_req=1: grant m1.
  - Otherwise, wait_cnt==MAX_WAIT and m1_req=1: grant m1.
  - Otherwise, m0_req=1: grant m0.
  - Otherwise, m1_req=1: grant m1.
  - Otherwise: no grant.
- The granted master's fields drive the dm_* outputs.
- With no grant: dm_we=0, dm_be=4'b0000, dm_addr=0, dm_di=0, is_signed=0, so no write can occur.
- A denied master's dm_we never reaches the MMU.
- Requesters hold all request fields stable until gnt. The arbiter has no backpressure beyond gnt.
- wait_cnt:
  - Clears when m1 is granted or m1_req=0.
  - Otherwise increments when m1_req=1 and not granted, saturating at MAX_WAIT.
- Lock state machine, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED at a clock edge where m1 is granted with m1_lock=1.
  - LOCKED -> UNLOCKED when m1_lock=0 or m1_req=0 at a clock edge.
  - In LOCKED, m0 is never granted, so cpu_stall=1 whenever m0_req=1.
- Response path:
  - owner_p registers the granted master (M0/M1/NONE) each cycle.
  - Next cycle, mX_rvalid=1 for owner_p=X, for both reads and writes.
  - mX_rdata=dm_do when owner_p=X, else 0.
  - dm_do is already extended and aligned by the MMU; the arbiter does not shift.
- Throughput: one access per cycle, back-to-back. A grant may coincide with the rvalid of the previous access, including to a different master.
- Simultaneous requests with wait_cnt<MAX_WAIT and not locked: m0 wins, m1 waits, wait_cnt increments.
- m1_lock asserted while m1 is not granted has no effect until m1 wins.

Test Plan:
- Reset, then m0 reads 0x00000010 (be=1111), m1 idle -> m0_gnt same cycle, dm_addr=0x10, next cycle m0_rvalid=1, m0_rdata=dm_do, m1_rvalid=0.
- No requests -> dm_we=0, dm_be=0000 every cycle, no rvalid.
- m0_req held high continuously, m1 writes 0x80000004 data 0xA5 be=0001 from cycle 0, MAX_WAIT=8 -> m1 denied cycles 0..7, granted cycle 8 with dm_we=1, dm_di=0xA5, dm_be=0001, cpu_stall=1 only in cycle 8; wait_cnt=0 afterward.
- m1 burst of 4 writes with m1_lock=1, m0_req high from the 2nd write -> m1 gets 4 consecutive grants, m0 stalled throughout; m1_lock=0 on the 4th -> m0 granted the following cycle.
- Alternating grants m0,m1,m0 on consecutive cycles with distinct dm_do values 0x11,0x22,0x33 -> m0_rdata=0x11, m1_rdata=0x22, m0_rdata=0x33 in the corresponding following cycles, no cross-routing.
- resetb low in the cycle after an m1 grant while locked -> m1_rvalid=0, lock cleared; m0 granted on the first post-reset request.
